// File: rtl/reg_to_apb.sv
// ---------------------------------------------------------------------------
// reg_to_apb
//   Bridges a register-interface request/response pair onto an APB4
//   completer port. One request is in flight at a time: it is latched in
//   IDLE, driven as an APB SETUP then ACCESS phase, and the result is
//   returned as a one-cycle ready pulse in DONE. A hung completer is cut off
//   after TimeoutCycles ACCESS cycles and reported as an error.
//
// Ports
//   clk_i, rst_i      : clock, synchronous active-high reset
//   reg_req_i         : register request  (addr, write, wdata, wstrb, valid)
//   reg_rsp_o         : register response (rdata, error, ready)
//   paddr_o .. pstrb_o: registered APB requester outputs, pprot_o tied 0
//   prdata_i, pready_i, pslverr_i : APB completer response
//
// Handshake: upstream raises valid and holds the request stable until it
// sees ready (a single-cycle pulse). rdata/error are meaningful only while
// ready is high. A request is taken only in IDLE, so a valid still high in
// DONE is ignored for that cycle and starts a new transfer in the next IDLE
// cycle. All outputs come straight from flops, so no APB input or request
// field reaches an output combinationally.
// ---------------------------------------------------------------------------
module reg_to_apb #(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned TimeoutCycles = 255,
  parameter type req_t = struct packed {
    logic [AW-1:0]   addr;
    logic            write;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            valid;
  },
  parameter type rsp_t = struct packed {
    logic [DW-1:0] rdata;
    logic          error;
    logic          ready;
  }
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  req_t            reg_req_i,
  output rsp_t            reg_rsp_o,
  output logic [AW-1:0]   paddr_o,
  output logic [2:0]      pprot_o,
  output logic            psel_o,
  output logic            penable_o,
  output logic            pwrite_o,
  output logic [DW-1:0]   pwdata_o,
  output logic [DW/8-1:0] pstrb_o,
  input  logic [DW-1:0]   prdata_i,
  input  logic            pready_i,
  input  logic            pslverr_i
);

  // Counter is at least one bit wide so a disabled timeout still elaborates.
  localparam int CW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [AW-1:0]     r_paddr;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [DW-1:0]     r_pwdata;
  logic [DW/8-1:0]   r_pstrb;
  logic [DW-1:0]     r_rdata;
  logic              r_error;
  logic              r_ready;
  logic              w_timeout;

  // Timeout fires on the ACCESS cycle that would be the TimeoutCycles-th
  // without pready; pready in that same cycle still wins.
  assign w_timeout = (TimeoutCycles != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_rdata   <= '0;
      r_error   <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (reg_req_i.valid) begin
            r_paddr  <= reg_req_i.addr;
            r_pwrite <= reg_req_i.write;
            r_pwdata <= reg_req_i.wdata;
            r_pstrb  <= reg_req_i.write ? reg_req_i.wstrb : '0;
            r_cnt    <= '0;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_i) begin
            r_rdata   <= r_pwrite ? '0 : prdata_i;
            r_error   <= pslverr_i;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= ST_DONE;
          end else if (w_timeout) begin
            r_rdata   <= '0;
            r_error   <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= ST_DONE;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign paddr_o   = r_paddr;
  assign pprot_o   = 3'b000;
  assign psel_o    = r_psel;
  assign penable_o = r_penable;
  assign pwrite_o  = r_pwrite;
  assign pwdata_o  = r_pwdata;
  assign pstrb_o   = r_pstrb;

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.rdata = r_rdata;
    reg_rsp_o.error = r_error;
    reg_rsp_o.ready = r_ready;
  end

endmodule

// File: tb/tb_reg_to_apb.sv
// ---------------------------------------------------------------------------
// tb_reg_to_apb
//   Self-checking bench for reg_to_apb with TimeoutCycles = 4. A table of
//   request records is driven one at a time; the driver plays the APB
//   completer and checks phase timing and field stability, while a monitor
//   pops expected {error, rdata} from a queue on every ready pulse.
//   Hand-written sequences cover back-to-back requests and reset mid-ACCESS.
//
//   Cycle accounting: the edge that samples valid in IDLE is cycle 0, SETUP
//   is cycle 1, ACCESS starts at cycle 2, ready arrives the cycle after the
//   last ACCESS cycle. A timeout ends after TimeoutCycles ACCESS cycles.
// ---------------------------------------------------------------------------
module tb_reg_to_apb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          valid;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          error;
    logic          ready;
  } rsp_t;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] prdata;
    logic          slverr;
    int            waits;      // ACCESS cycles with pready low; >= TO means never ready
    bit            drop_valid; // drop valid right after acceptance
    logic [DW-1:0] exp_rdata;
    logic          exp_error;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  req_t          req;
  rsp_t          rsp;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  always #5 clk = ~clk;

  reg_to_apb #(
    .AW(AW), .DW(DW), .TimeoutCycles(TO), .req_t(req_t), .rsp_t(rsp_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .reg_req_i (req),
    .reg_rsp_o (rsp),
    .paddr_o   (paddr),
    .pprot_o   (pprot),
    .psel_o    (psel),
    .penable_o (penable),
    .pwrite_o  (pwrite),
    .pwdata_o  (pwdata),
    .pstrb_o   (pstrb),
    .prdata_i  (prdata),
    .pready_i  (pready),
    .pslverr_i (pslverr)
  );

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_err    = 0;
  logic [DW:0]   exp_q[$];   // {error, rdata}
  logic [DW:0]   mon_e;
  int            n_pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rsp.ready) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        chk("ready_unexpected", 64'(rsp.ready), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp.rdata), 64'(mon_e[DW-1:0]));
        chk("rsp_error", 64'(rsp.error), 64'(mon_e[DW]));
      end
    end
  end

  // ---------------- driver ----------------
  function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [SW-1:0] st, input logic [DW-1:0] prd, input logic se,
                              input int waits, input bit drop,
                              input logic [DW-1:0] er, input logic ee);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = wd; v.wstrb = st; v.prdata = prd; v.slverr = se;
    v.waits = waits; v.drop_valid = drop; v.exp_rdata = er; v.exp_error = ee;
    return v;
  endfunction

  // Called at a negedge. exp_setup is the cycle (counted in negedges from
  // the drive point) at which SETUP must appear.
  task automatic run_vec(input vec_t v, input int exp_setup, input bit keep_valid);
    int            cyc;
    int            setup_at;
    int            ready_at;
    int            acc;
    int            exp_ready;
    int            exp_acc;
    bit            stable;
    logic [SW-1:0] exp_strb;
    exp_strb  = v.write ? v.wstrb : '0;
    exp_acc   = (v.waits >= TO) ? TO : v.waits + 1;
    exp_ready = exp_setup + exp_acc + 1;

    req.addr  = v.addr;
    req.write = v.write;
    req.wdata = v.wdata;
    req.wstrb = v.wstrb;
    req.valid = 1'b1;
    exp_q.push_back({v.exp_error, v.exp_rdata});
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = $urandom;

    cyc = 0;
    setup_at = -1;
    while (setup_at < 0 && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (psel) setup_at = cyc;
    end
    chk("setup_cycle", 64'(setup_at), 64'(exp_setup));
    chk("setup_penable", 64'(penable), 64'd0);
    chk("setup_paddr", 64'(paddr), 64'(v.addr));
    chk("setup_pwrite", 64'(pwrite), 64'(v.write));
    chk("setup_pwdata", 64'(pwdata), 64'(v.wdata));
    chk("setup_pstrb", 64'(pstrb), 64'(exp_strb));
    chk("setup_pprot", 64'(pprot), 64'd0);
    if (v.drop_valid) req.valid = 1'b0;

    acc = 0;
    ready_at = -1;
    stable = 1'b1;
    while (ready_at < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rsp.ready) begin
        ready_at = cyc;
        chk("done_psel", 64'({psel, penable}), 64'd0);
      end else if (psel && penable) begin
        if (paddr !== v.addr || pwrite !== v.write || pwdata !== v.wdata || pstrb !== exp_strb)
          stable = 1'b0;
        pready  = (acc == v.waits);
        prdata  = pready ? v.prdata : $urandom;
        pslverr = pready ? v.slverr : 1'($urandom);
        acc++;
      end else begin
        stable = 1'b0;
      end
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    chk("ready_cycle", 64'(ready_at), 64'(exp_ready));
    chk("access_cycles", 64'(acc), 64'(exp_acc));
    chk("apb_stable", 64'(stable), 64'd1);
    if (!keep_valid) req.valid = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t vecs[8];
  vec_t va, vb;
  logic [DW-1:0] rnd;

  initial begin
    rnd = $urandom;
    vecs[0] = mk(1'b0, 32'h40, 32'h0,        4'hF,    32'hCAFEF00D, 1'b0, 0,  1'b0, 32'hCAFEF00D, 1'b0);
    vecs[1] = mk(1'b1, 32'h44, 32'h12345678, 4'b0101, 32'hDEADBEEF, 1'b0, 3,  1'b0, 32'h0,        1'b0);
    vecs[2] = mk(1'b0, 32'h48, 32'h0,        4'h0,    32'hA5A5A5A5, 1'b1, 0,  1'b0, 32'hA5A5A5A5, 1'b1);
    vecs[3] = mk(1'b0, 32'h4C, 32'h0,        4'h0,    32'h0BADF00D, 1'b0, 1,  1'b0, 32'h0BADF00D, 1'b0);
    vecs[4] = mk(1'b0, 32'h50, 32'h0,        4'h0,    32'hFFFFFFFF, 1'b0, 99, 1'b0, 32'h0,        1'b1);
    vecs[5] = mk(1'b1, 32'h54, rnd,          4'hF,    32'h77777777, 1'b1, 2,  1'b1, 32'h0,        1'b1);
    vecs[6] = mk(1'b0, 32'h58, 32'h0,        4'h3,    32'h13579BDF, 1'b0, 3,  1'b0, 32'h13579BDF, 1'b0);
    vecs[7] = mk(1'b1, 32'h5C, 32'hFEEDFACE, 4'h8,    32'h11111111, 1'b0, 99, 1'b0, 32'h0,        1'b1);

    rst = 1'b1;
    req = '0;
    prdata = '0;
    pready = 1'b0;
    pslverr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_psel_penable_pwrite", 64'({psel, penable, pwrite}), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_pstrb", 64'(pstrb), 64'd0);
    chk("rst_rsp", 64'(rsp), 64'd0);

    // table-driven vectors, one idle cycle between requests
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run_vec(vecs[i], 1, 1'b0);
    end

    // back-to-back: valid stays high through A's DONE; B is driven in that
    // DONE cycle and must be taken only in the following IDLE cycle, so B's
    // SETUP lands 4 cycles after A's SETUP.
    @(negedge clk);
    va = mk(1'b0, 32'h80, 32'h0, 4'h0, $urandom, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    va.exp_rdata = va.prdata;
    vb = mk(1'b1, 32'h84, $urandom, 4'b1010, 32'h22222222, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    run_vec(va, 1, 1'b1);
    run_vec(vb, 2, 1'b0);

    // reset during ACCESS: no pulse for the aborted transfer
    @(negedge clk);
    req.addr = 32'h60; req.write = 1'b0; req.wdata = '0; req.wstrb = '0; req.valid = 1'b1;
    pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_access", 64'({psel, penable}), 64'd3);
    rst = 1'b1;
    req.valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_psel_penable", 64'({psel, penable}), 64'd0);
    chk("post_rst_ready", 64'(rsp.ready), 64'd0);
    chk("post_rst_paddr", 64'(paddr), 64'd0);
    chk("post_rst_rsp", 64'(rsp), 64'd0);
    repeat (6) @(negedge clk);
    chk("post_rst_idle_psel", 64'(psel), 64'd0);
    run_vec(mk(1'b0, 32'h64, 32'h0, 4'h0, 32'h600DCAFE, 1'b0, 1, 1'b0, 32'h600DCAFE, 1'b0), 1, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("pulse_count", 64'(n_pulses), 64'd11);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

endmodule
